// File: rtl/pkt_unit_sched_pkg.sv
// Shared definitions for the per-packet unit scheduler: unit indices,
// completion status codes and sequencer state encoding.
package pkt_unit_sched_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [1:0] UNIT_MNI    = 2'd0;
  localparam logic [1:0] UNIT_KCH    = 2'd1;
  localparam logic [1:0] UNIT_REWARD = 2'd2;
  localparam logic [1:0] UNIT_QTU    = 2'd3;

  typedef enum logic [1:0] {
    PKT_OK      = 2'd0,
    PKT_TIMEOUT = 2'd1,
    PKT_NOOP    = 2'd2
  } pkt_status_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILT = 3'd1,
    S_CAPT = 3'd2,
    S_DISP = 3'd3,
    S_RUN  = 3'd4,
    S_FIN  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/pkt_unit_sched_if.sv
// Bundle of RX, filter, processing-unit and host signals around the scheduler.
interface pkt_unit_sched_if
  import pkt_unit_sched_pkg::*;
#(
  parameter int DROP_W = 8
);
  logic              newpkt;
  logic              pkt_busy;
  logic              filt_newpkt;
  logic              en_MNI, en_KCH, en_reward, en_QTU;
  logic              iAmDestination;
  logic              start_MNI, start_KCH, start_reward, start_QTU;
  logic              done_MNI, done_KCH, done_reward, done_QTU;
  logic              mem_gnt_valid;
  logic [1:0]        mem_gnt;
  logic              pkt_done;
  pkt_status_e       pkt_status;
  logic              to_host;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    input  newpkt, en_MNI, en_KCH, en_reward, en_QTU, iAmDestination,
           done_MNI, done_KCH, done_reward, done_QTU,
    output pkt_busy, filt_newpkt, start_MNI, start_KCH, start_reward, start_QTU,
           mem_gnt_valid, mem_gnt, pkt_done, pkt_status, to_host, drop_cnt
  );

  modport slave (
    output newpkt, en_MNI, en_KCH, en_reward, en_QTU, iAmDestination,
           done_MNI, done_KCH, done_reward, done_QTU,
    input  pkt_busy, filt_newpkt, start_MNI, start_KCH, start_reward, start_QTU,
           mem_gnt_valid, mem_gnt, pkt_done, pkt_status, to_host, drop_cnt
  );

endinterface

// File: rtl/sched_timeout_ctr.sv
// Grant-hold watchdog: counts RUN cycles and flags the last permitted one.
module sched_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pkt_unit_sched.sv
// Per-packet sequencer: pulses the filter, then starts each enabled unit in
// MNI/KCH/reward/QTU order while it owns the shared node-memory port.
module pkt_unit_sched
  import pkt_unit_sched_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DROP_W  = 8
) (
  input  logic             clk,
  input  logic             nrst,
  pkt_unit_sched_if.master bus
);
  sched_state_e      state;
  logic [3:0]        pending, en_mask, done_mask, rem_mask, sel_mask, start_q;
  logic [1:0]        pick, gnt_q;
  logic              gnt_valid_q, busy_q, filt_q, done_q, to_host_q, dest_q, ran_q;
  logic              tc, unit_done;
  pkt_status_e       status_q;
  logic [DROP_W-1:0] drop_q;

  // The mask being dispatched next depends on where we enter DISP from,
  // so the start pulse lines up with the DISP cycle itself.
  always_comb begin
    en_mask   = {bus.en_QTU, bus.en_reward, bus.en_KCH, bus.en_MNI};
    done_mask = {bus.done_QTU, bus.done_reward, bus.done_KCH, bus.done_MNI};
    rem_mask  = pending & ~(4'b0001 << gnt_q);
    unit_done = done_mask[gnt_q];
    sel_mask  = pending;
    if (state == S_CAPT) sel_mask = en_mask;
    else if (state == S_RUN) sel_mask = rem_mask;
    pick = UNIT_QTU;
    if (sel_mask[0])      pick = UNIT_MNI;
    else if (sel_mask[1]) pick = UNIT_KCH;
    else if (sel_mask[2]) pick = UNIT_REWARD;
  end

  sched_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (nrst),
    .clr (state == S_DISP),
    .en  (state == S_RUN),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      state       <= S_IDLE;
      pending     <= '0;
      start_q     <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      filt_q      <= 1'b0;
      done_q      <= 1'b0;
      to_host_q   <= 1'b0;
      dest_q      <= 1'b0;
      ran_q       <= 1'b0;
      status_q    <= PKT_OK;
      drop_q      <= '0;
    end else begin
      filt_q    <= 1'b0;
      start_q   <= '0;
      done_q    <= 1'b0;
      to_host_q <= 1'b0;
      if (bus.newpkt && busy_q && (drop_q != {DROP_W{1'b1}})) begin
        drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
      end
      unique case (state)
        S_IDLE: if (bus.newpkt) begin
          state  <= S_FILT;
          busy_q <= 1'b1;
          filt_q <= 1'b1;
        end
        S_FILT: state <= S_CAPT;
        S_CAPT: begin
          pending <= en_mask;
          dest_q  <= bus.iAmDestination;
          ran_q   <= 1'b0;
          if (en_mask != '0) start_q[pick] <= 1'b1;
          state   <= S_DISP;
        end
        S_DISP: if (pending == '0) begin
          state     <= S_FIN;
          done_q    <= 1'b1;
          status_q  <= ran_q ? PKT_OK : PKT_NOOP;
          to_host_q <= ran_q && dest_q;
        end else begin
          state       <= S_RUN;
          gnt_q       <= pick;
          gnt_valid_q <= 1'b1;
          ran_q       <= 1'b1;
        end
        S_RUN: if (unit_done) begin
          pending     <= rem_mask;
          gnt_valid_q <= 1'b0;
          if (rem_mask != '0) start_q[pick] <= 1'b1;
          state       <= S_DISP;
        end else if (tc) begin
          pending     <= '0;
          gnt_valid_q <= 1'b0;
          status_q    <= PKT_TIMEOUT;
          done_q      <= 1'b1;
          state       <= S_FIN;
        end
        S_FIN: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pkt_busy      = busy_q;
  assign bus.filt_newpkt   = filt_q;
  assign bus.start_MNI     = start_q[UNIT_MNI];
  assign bus.start_KCH     = start_q[UNIT_KCH];
  assign bus.start_reward  = start_q[UNIT_REWARD];
  assign bus.start_QTU     = start_q[UNIT_QTU];
  assign bus.mem_gnt_valid = gnt_valid_q;
  assign bus.mem_gnt       = gnt_q;
  assign bus.pkt_done      = done_q;
  assign bus.pkt_status    = status_q;
  assign bus.to_host       = to_host_q;
  assign bus.drop_cnt      = drop_q;

endmodule

// File: tb/tb_pkt_unit_sched.sv
// Bench for pkt_unit_sched: per-packet timelines predicted from the sequencing
// rules, driven with random enables, unit latencies and stray inputs.
module tb_pkt_unit_sched;
  import pkt_unit_sched_pkg::*;

  localparam int TO = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic nrst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   drops = 0;

  always #5 clk = ~clk;

  pkt_unit_sched_if #(.DROP_W(DW)) bus ();

  pkt_unit_sched #(.TIMEOUT(TO), .DROP_W(DW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.master)
  );

  // Expected outputs per packet-relative cycle:
  // [12]busy [11]filt [10:7]start{QTU,reward,KCH,MNI} [6]gnt_valid [5:4]gnt
  // [3]pkt_done [2:1]status [0]to_host
  logic [12:0] e_out  [0:127];
  logic        i_new  [0:127];
  logic [3:0]  i_done [0:127];
  logic [3:0]  gnt_of [0:127];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] observe();
    return {bus.pkt_busy, bus.filt_newpkt,
            bus.start_QTU, bus.start_reward, bus.start_KCH, bus.start_MNI,
            bus.mem_gnt_valid, (bus.mem_gnt_valid ? bus.mem_gnt : 2'b00),
            bus.pkt_done, (bus.pkt_done ? 2'(bus.pkt_status) : 2'b00), bus.to_host};
  endfunction

  task automatic drive_idle();
    bus.newpkt = 1'b0;
    bus.iAmDestination = 1'b0;
    {bus.en_QTU, bus.en_reward, bus.en_KCH, bus.en_MNI} = 4'b0;
    {bus.done_QTU, bus.done_reward, bus.done_KCH, bus.done_MNI} = 4'b0;
  endtask

  // dN: cycles from start to done for unit N; 0 = done only during its
  // dispatch cycle (ignored); above TO = never answers.
  task automatic run_pkt(input logic [3:0] en, input logic dest,
                         input int d0, input int d1, input int d2, input int d3,
                         input int p_noise, input int p_new);
    int dl[4];
    int d, fin, st, hold;
    dl = '{d0, d1, d2, d3};
    for (int r = 0; r < 128; r++) begin
      e_out[r] = '0; i_new[r] = 1'b0; i_done[r] = '0; gnt_of[r] = '0;
    end
    d = 3; fin = -1; st = 0;
    for (int u = 0; u < 4; u++) begin
      if (en[u] && fin < 0) begin
        e_out[d][7+u] = 1'b1;
        hold = (dl[u] >= 1 && dl[u] <= TO) ? dl[u] : TO;
        for (int t = d + 1; t <= d + hold; t++) begin
          e_out[t][6] = 1'b1; e_out[t][5:4] = 2'(u); gnt_of[t][u] = 1'b1;
        end
        if (dl[u] >= 1 && dl[u] <= TO) begin
          i_done[d+dl[u]][u] = 1'b1;
          d = d + dl[u] + 1;
        end else begin
          if (dl[u] == 0) i_done[d][u] = 1'b1;
          fin = d + TO + 1;
          st = 1;
        end
      end
    end
    if (fin < 0) begin
      fin = d + 1;
      st = (en == 4'b0) ? 2 : 0;
    end
    e_out[1][11] = 1'b1;
    for (int r = 1; r <= fin; r++) e_out[r][12] = 1'b1;
    e_out[fin][3] = 1'b1;
    e_out[fin][2:1] = 2'(st);
    e_out[fin][0] = dest && (st == 0);
    i_new[0] = 1'b1;
    for (int r = 1; r <= fin; r++) begin
      if ($urandom_range(99) < p_new) i_new[r] = 1'b1;
      for (int x = 0; x < 4; x++)
        if (!gnt_of[r][x] && $urandom_range(99) < p_noise) i_done[r][x] = 1'b1;
    end
    for (int r = 0; r <= fin + 1; r++) begin
      @(negedge clk);
      chk($sformatf("out_r%0d", r), observe(), e_out[r]);
      chk($sformatf("drop_r%0d", r), bus.drop_cnt, drops);
      bus.newpkt = i_new[r];
      {bus.done_QTU, bus.done_reward, bus.done_KCH, bus.done_MNI} = i_done[r];
      {bus.en_QTU, bus.en_reward, bus.en_KCH, bus.en_MNI} = (r == 2) ? en : 4'($urandom);
      bus.iAmDestination = (r == 2) ? dest : 1'($urandom);
      if (i_new[r] && r >= 1 && drops < 255) drops++;
    end
  endtask

  initial begin
    drive_idle();
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out", observe(), 0);
    chk("rst_drop", bus.drop_cnt, 0);
    nrst = 1'b0;

    run_pkt(4'b1001, 1'b0, 3, 3, 3, 3, 0, 0);
    run_pkt(4'b1111, 1'b1, 2, 2, 2, 2, 0, 0);
    run_pkt(4'b0000, 1'b1, 0, 0, 0, 0, 0, 0);
    run_pkt(4'b1110, 1'b1, 0, TO + 5, 2, 2, 0, 0);
    run_pkt(4'b0110, 1'b1, 0, TO, 1, 0, 0, 0);
    run_pkt(4'b0001, 1'b0, 0, 0, 0, 0, 0, 0);
    run_pkt(4'b1001, 1'b1, TO - 1, 2, 2, 3, 40, 0);

    for (int n = 0; n < 30; n++)
      run_pkt(4'($urandom), 1'($urandom), $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
              $urandom_range(0, TO + 2), $urandom_range(0, TO + 2), 15, 25);

    for (int n = 0; n < 10; n++)
      run_pkt(4'b1111, 1'b0, TO, TO, TO, TO, 20, 100);
    @(negedge clk);
    chk("drop_sat", bus.drop_cnt, 255);

    // Reset while a unit holds the memory port.
    drive_idle();
    bus.newpkt = 1'b1;
    @(negedge clk); bus.newpkt = 1'b0;
    @(negedge clk); {bus.en_QTU, bus.en_reward, bus.en_KCH, bus.en_MNI} = 4'b1111;
    @(negedge clk); {bus.en_QTU, bus.en_reward, bus.en_KCH, bus.en_MNI} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_gv", bus.mem_gnt_valid, 1);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_run_out", observe(), 0);
    chk("rst_run_drop", bus.drop_cnt, 0);
    drops = 0;
    nrst = 1'b0;
    run_pkt(4'b0101, 1'b1, 2, 0, 4, 0, 10, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
